// File: rtl/muldiv_share_arb_if.sv
// muldiv_share_arb_if
// Groups the two requester handshakes and the shared result bus of the
// multiply/divide arbiter into one bundle.
//   req0/op0/a0/b0 : requester 0 request, operation (0 mul, 1 div), operands
//   req1/op1/a1/b1 : requester 1, same meaning
//   gnt0/gnt1      : one-cycle grant pulse, operands have been captured
//   done0/done1    : one-cycle result-valid pulse for the owning requester
//   res            : shared result bus, {remainder, quotient} for divides
//   dz             : divide-by-zero flag belonging to the current res
// Modports: slave = arbiter side, master = client/testbench side.
interface muldiv_share_arb_if #(
  parameter int AW = 17,
  parameter int BW = 16
);
  localparam int RW = AW + BW;

  logic          req0;
  logic          op0;
  logic [AW-1:0] a0;
  logic [BW-1:0] b0;
  logic          req1;
  logic          op1;
  logic [AW-1:0] a1;
  logic [BW-1:0] b1;
  logic          gnt0;
  logic          gnt1;
  logic          done0;
  logic          done1;
  logic [RW-1:0] res;
  logic          dz;

  modport slave (
    input  req0, op0, a0, b0, req1, op1, a1, b1,
    output gnt0, gnt1, done0, done1, res, dz
  );

  modport master (
    output req0, op0, a0, b0, req1, op1, a1, b1,
    input  gnt0, gnt1, done0, done1, res, dz
  );
endinterface

// File: rtl/muldiv_share_arb.sv
// muldiv_share_arb
// Round-robin scheduler sharing one iterative shift-add multiplier and
// restoring divider between two requesters. Multiply results are ready 17
// clocks after the request-sampling edge, divide results 18 clocks after it.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, drops any transaction in flight
//   bus   : muldiv_share_arb_if.slave (requests, grants, done, res, dz)
module muldiv_share_arb #(
  parameter int AW = 17,
  parameter int BW = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  muldiv_share_arb_if.slave    bus
);
  localparam int RW = AW + BW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t        state_r;
  logic [4:0]    count_r;
  logic          last_r;
  logic          owner_r;
  logic [AW-1:0] a_r;
  logic [BW-1:0] b_r;
  logic [RW-1:0] acc_r;
  logic [BW-1:0] rem_r;
  logic [AW-1:0] quo_r;
  logic          dz_pend_r;
  logic          gnt0_r;
  logic          gnt1_r;
  logic          done0_r;
  logic          done1_r;
  logic [RW-1:0] res_r;
  logic          dz_r;

  logic          any_req_s;
  logic          win_s;
  logic          sel_op_s;
  logic [AW-1:0] sel_a_s;
  logic [BW-1:0] sel_b_s;
  logic [RW-1:0] partial_s;
  logic [BW:0]   trial_s;
  logic          ge_s;
  logic [BW-1:0] rem_next_s;

  // Winner selection: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    any_req_s = bus.req0 | bus.req1;
    win_s     = 1'b0;
    if (bus.req0 && bus.req1) begin
      win_s = ~last_r;
    end else begin
      win_s = bus.req1;
    end
    if (win_s) begin
      sel_op_s = bus.op1;
      sel_a_s  = bus.a1;
      sel_b_s  = bus.b1;
    end else begin
      sel_op_s = bus.op0;
      sel_a_s  = bus.a0;
      sel_b_s  = bus.b0;
    end
  end

  // Datapath step terms: shifted multiplicand and one restoring-division trial.
  always_comb begin
    partial_s = {{BW{1'b0}}, a_r} << count_r[3:0];
    // a_r is shifted left each divide step, so its MSB is the next dividend bit.
    trial_s   = {rem_r, a_r[AW-1]};
    ge_s      = (trial_s >= {1'b0, b_r});
    if (ge_s) begin
      rem_next_s = BW'(trial_s - {1'b0, b_r});
    end else begin
      rem_next_s = trial_s[BW-1:0];
    end
  end

  // Scheduler FSM, iterative datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      count_r   <= 5'd0;
      last_r    <= 1'b1;
      owner_r   <= 1'b0;
      a_r       <= {AW{1'b0}};
      b_r       <= {BW{1'b0}};
      acc_r     <= {RW{1'b0}};
      rem_r     <= {BW{1'b0}};
      quo_r     <= {AW{1'b0}};
      dz_pend_r <= 1'b0;
      gnt0_r    <= 1'b0;
      gnt1_r    <= 1'b0;
      done0_r   <= 1'b0;
      done1_r   <= 1'b0;
      res_r     <= {RW{1'b0}};
      dz_r      <= 1'b0;
    end else begin
      gnt0_r  <= 1'b0;
      gnt1_r  <= 1'b0;
      done0_r <= 1'b0;
      done1_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            owner_r   <= win_s;
            last_r    <= win_s;
            a_r       <= sel_a_s;
            b_r       <= sel_b_s;
            count_r   <= 5'd0;
            acc_r     <= {RW{1'b0}};
            rem_r     <= {BW{1'b0}};
            quo_r     <= {AW{1'b0}};
            dz_pend_r <= sel_op_s & (sel_b_s == {BW{1'b0}});
            gnt0_r    <= ~win_s;
            gnt1_r    <= win_s;
            state_r   <= sel_op_s ? DIV : MUL;
          end
        end
        MUL: begin
          // Sixteen add steps (count 0..15), then the product is published.
          if (count_r == 5'd16) begin
            res_r   <= acc_r;
            dz_r    <= 1'b0;
            done0_r <= ~owner_r;
            done1_r <= owner_r;
            state_r <= FIN;
          end else begin
            if (b_r[count_r[3:0]]) begin
              acc_r <= acc_r + partial_s;
            end
            count_r <= count_r + 5'd1;
          end
        end
        DIV: begin
          // Seventeen trial steps (count 0..16); a zero divisor still runs the
          // full pass so latency does not depend on the operands.
          if (count_r == 5'd17) begin
            if (dz_pend_r) begin
              res_r <= {{BW{1'b0}}, {AW{1'b1}}};
            end else begin
              res_r <= {rem_r, quo_r};
            end
            dz_r    <= dz_pend_r;
            done0_r <= ~owner_r;
            done1_r <= owner_r;
            state_r <= FIN;
          end else begin
            rem_r   <= rem_next_s;
            quo_r   <= {quo_r[AW-2:0], ge_s};
            a_r     <= {a_r[AW-2:0], 1'b0};
            count_r <= count_r + 5'd1;
          end
        end
        FIN: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt0  = gnt0_r;
  assign bus.gnt1  = gnt1_r;
  assign bus.done0 = done0_r;
  assign bus.done1 = done1_r;
  assign bus.res   = res_r;
  assign bus.dz    = dz_r;
endmodule

// File: doc/muldiv_share_arb.md
Name: muldiv_share_arb

Overview:
- Round-robin scheduler that shares one iterative shift-add multiplier / restoring divider between two requesters.
- Replaces two combinational `*`/`/` datapaths, each with a 17-bit dividend/multiplicand and 16-bit operand, with a single multicycle unit.
- Sits between the two compute clients and the shared arithmetic core. It sequences the core through fixed-length multiply and divide passes.

Parameters:
- AW, 17, width of operand A (multiplicand / dividend)
- BW, 16, width of operand B (multiplier / divisor)
- RW, AW+BW (33), result bus width

Ports:
- CLK  input  1  rising-edge clock
- RST_N  input  1  asynchronous active-low reset
- REQ0  input  1  requester 0 transaction request
- OP0  input  1  requester 0 operation: 0 = multiply, 1 = divide
- A0  input  AW  requester 0 operand A
- B0  input  BW  requester 0 operand B
- REQ1/OP1/A1/B1  input  1/1/AW/BW  requester 1, same meaning as requester 0
- GNT0, GNT1  output  1  one-cycle grant pulse; operands were captured
- DONE0, DONE1  output  1  one-cycle result-valid pulse
- RES  output  RW  shared result bus
- DZ  output  1  divide-by-zero flag for the current RES

Behaviour:
- Reset: asynchronous on RST_N low. All outputs are 0, state is IDLE, counters are 0, and the round-robin pointer LAST is 1, so requester 0 wins the first tie.
- Reset mid-operation: the transaction is dropped silently, with no DONE pulse.
- FSM states: IDLE, MUL, DIV, FIN.
- IDLE: REQs are sampled at each edge.
  - If any REQ is high, select the winner: the one requester asserting, or on a tie the requester other than LAST.
  - Latch OPx, Ax and Bx, set LAST = winner, and go to MUL or DIV with count = 0.
  - GNTx is high for exactly the one cycle after that edge.
- MUL: 16 cycles, count 0..15.
  - Each cycle: if B[count] is set, acc += A << count. acc is RW bits and never overflows.
  - Then go to FIN.
- DIV: 17 cycles, restoring division MSB-first over the AW dividend bits.
  - Partial remainder is BW+1 bits.
  - Quotient is AW bits and remainder is BW bits.
  - Then go to FIN.
- Divide by zero (B == 0) is detected on entry to DIV. Still take the full 17 cycles for fixed latency. The result is quotient = all ones (17'h1FFFF), remainder = 0, DZ = 1.
- FIN: one cycle.
  - DONEx = 1 for the owning requester only.
  - RES is loaded on entry to FIN. Multiply: RES = product. Divide: RES = {remainder[BW-1:0], quotient[AW-1:0]}.
  - DZ is loaded with RES.
  - Return to IDLE.
- RES and DZ hold their value until the next FIN; they are not cleared when DONE falls.
- Latency, from the REQ-sampling edge to the DONE cycle: multiply 17 clocks, divide 18 clocks. There is one further IDLE cycle before the next grant.
- Handshake:
  - A requester holds REQ and operands stable until it sees GNT.
  - Operand changes after GNT have no effect on the transaction in flight.
  - REQ still high in IDLE after a DONE is a new request, so back-to-back requests are legal.
- Simultaneous REQ0 and REQ1 held continuously: grants strictly alternate 0,1,0,1...
- A requester never starves; it waits at most one transaction of the other requester.
- REQ changes while busy are ignored until IDLE.
- GNT and DONE are never asserted together, and never for both requesters at once.

Test Plan:
- Reset, then REQ0 with OP0=0, A0=5, B0=3 → GNT0 one cycle after the sampling edge; DONE0 17 clocks after that edge with RES=15, DZ=0; GNT1/DONE1 stay 0.
- REQ1 with OP1=1, A1=100000, B1=7 → DONE1 18 clocks after the sampling edge with RES[16:0]=14285, RES[32:17]=5, DZ=0.
- REQ0 with OP0=0, A0=131071, B0=65535 → RES=8589737985. Then REQ0 with OP0=1, A0=1234, B0=0 → RES[16:0]=17'h1FFFF, RES[32:17]=0, DZ=1.
- REQ0 and REQ1 held high together from reset, both multiplying 2*2 → grant order 0,1,0,1. Each DONE returns RES=4. No overlapping GNT/DONE. The next GNT comes one idle cycle after the previous DONE.
- RST_N pulsed low 8 cycles into a divide → all outputs 0 immediately, with no DONE. After release, a tie grants requester 0 first.
- Change A0 in the cycle after GNT0 for multiply 9*9 → RES=81; the change is ignored.
